packetizer_ni: RTL and testbench

- Transmit-side network interface: turns a core's stream of payload words into head/body/tail flits and feeds one router input port (data/valid/ready).
- Inserts a head flit carrying source and destination node indices, then numbers the following payload words as body flits and finally a tail flit.
- The output is a registered, one-entry pipeline stage that sustains 1 flit/cycle after the head.

---
 rtl/packetizer_ni.sv | 172 +++++++++++++++++
 tb/tb_packetizer_ni.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/packetizer_ni.sv
// Transmit-side network interface: wraps core payload words into head/body/tail
// flits behind a single registered output slot feeding one router input port.
module packetizer_ni #(
    parameter int N             = 100,
    parameter int INDEX         = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6,
    parameter int CNT_WIDTH     = 16,
    localparam int AW           = $clog2(N),
    localparam int PW           = DATA_WIDTH - TYPE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PW-1:0]         data_in,
    input  logic [AW-1:0]         dest_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  dest_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    localparam int CW         = $clog2(FlitPerPacket);
    localparam int LAST_INT   = FlitPerPacket - 2;
    localparam logic [CW-1:0] LAST_IDX = LAST_INT[CW-1:0];
    localparam logic [AW:0]   N_LIMIT  = N[AW:0];
    localparam logic [AW-1:0] SRC_IDX  = INDEX[AW-1:0];

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_valid_out;
    logic                    r_busy;
    logic [CNT_WIDTH-1:0]    r_pkt_count;
    logic                    r_dest_err;
    logic [CW-1:0]           r_word_cnt;

    state_t                  w_state_next;
    logic                    w_slot_free;
    logic                    w_ready_in;
    logic                    w_load;
    logic                    w_head_issue;
    logic                    w_tail_hs;
    logic                    w_is_last;
    logic                    w_dest_bad;
    logic [PW-1:0]           w_head_payload;
    logic [DATA_WIDTH-1:0]   w_flit;

    // Type field sits in the top bits; any type bits above the 2-bit code stay 0.
    function automatic logic [DATA_WIDTH-1:0] make_flit(input logic [1:0]    t,
                                                        input logic [PW-1:0] p);
        logic [DATA_WIDTH-1:0] f;
        f          = '0;
        f[PW-1:0]  = p;
        f[PW +: 2] = t;
        return f;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_next   = r_state;
        w_ready_in     = 1'b0;
        w_load         = 1'b0;
        w_head_issue   = 1'b0;
        w_tail_hs      = 1'b0;
        w_flit         = '0;
        w_slot_free    = !r_valid_out || ready_out;
        w_is_last      = (r_word_cnt == LAST_IDX);
        w_dest_bad     = ({1'b0, dest_in} >= N_LIMIT);
        w_head_payload = '0;
        w_head_payload[AW-1:0]    = dest_in;
        w_head_payload[2*AW-1:AW] = SRC_IDX;

        case (r_state)
            S_IDLE: begin
                if (valid_in && w_slot_free) begin
                    w_load       = 1'b1;
                    w_head_issue = 1'b1;
                    w_flit       = make_flit(T_HEAD, w_head_payload);
                    w_state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_ready_in = w_slot_free;
                if (valid_in && w_slot_free) begin
                    w_load = 1'b1;
                    w_flit = make_flit(w_is_last ? T_TAIL : T_BODY, data_in);
                    if (w_is_last) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The tail leaving frees the slot, so a waiting head can go straight in.
                if (r_valid_out && ready_out) begin
                    w_tail_hs = 1'b1;
                    if (valid_in) begin
                        w_load       = 1'b1;
                        w_head_issue = 1'b1;
                        w_flit       = make_flit(T_HEAD, w_head_payload);
                        w_state_next = S_PAYLOAD;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state     <= S_IDLE;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_count <= '0;
            r_dest_err  <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_load) begin
                r_data_out  <= w_flit;
                r_valid_out <= 1'b1;
            end else if (w_slot_free) begin
                r_valid_out <= 1'b0;
            end

            if (w_head_issue) begin
                r_word_cnt <= '0;
                if (w_dest_bad) begin
                    r_dest_err <= 1'b1;
                end
            end else if (w_load) begin
                r_word_cnt <= r_word_cnt + CW'(1);
            end

            if (w_head_issue) begin
                r_busy <= 1'b1;
            end else if (w_tail_hs) begin
                r_busy <= 1'b0;
            end

            if (w_tail_hs) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    assign ready_in  = w_ready_in;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign busy      = r_busy;
    assign pkt_count = r_pkt_count;
    assign dest_err  = r_dest_err;

endmodule

// File: tb/tb_packetizer_ni.sv
// Scoreboard bench for packetizer_ni: one instance with 6-flit packets and one with
// 2-flit packets share a driver/monitor selected by sel.
module tb_packetizer_ni;

    localparam int AW = 7;
    localparam int PW = 30;
    localparam int DW = 32;

    typedef struct {
        logic [PW-1:0] data;
        logic [AW-1:0] dest;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic          v = 1'b0;
    logic [PW-1:0] data_in = '0;
    logic [AW-1:0] dest_in = '0;
    logic          ready_out = 1'b1;

    logic          vin6, vin2, rdy6, rdy2, vo6, vo2, busy6, busy2, derr6, derr2;
    logic [DW-1:0] do6, do2;
    logic [15:0]   pc6, pc2;

    logic          m_valid, m_ready_in, m_busy, m_derr;
    logic [DW-1:0] m_data;
    logic [15:0]   m_pc;

    word_t         src_q[$];
    logic [DW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            cyc = 0;
    int            rmode = 0;
    logic [3:0]    rpat = 4'b1001;

    always #5 clk = ~clk;

    assign vin6       = v & ~sel;
    assign vin2       = v & sel;
    assign m_valid    = sel ? vo2   : vo6;
    assign m_ready_in = sel ? rdy2  : rdy6;
    assign m_data     = sel ? do2   : do6;
    assign m_busy     = sel ? busy2 : busy6;
    assign m_derr     = sel ? derr2 : derr6;
    assign m_pc       = sel ? pc2   : pc6;

    packetizer_ni #(.N(100), .INDEX(3), .DATA_WIDTH(32), .TYPE_WIDTH(2),
                    .FlitPerPacket(6), .CNT_WIDTH(16)) u_dut6 (
        .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in),
        .valid_in(vin6), .ready_in(rdy6), .data_out(do6), .valid_out(vo6),
        .ready_out(ready_out), .busy(busy6), .pkt_count(pc6), .dest_err(derr6)
    );

    packetizer_ni #(.N(100), .INDEX(3), .DATA_WIDTH(32), .TYPE_WIDTH(2),
                    .FlitPerPacket(2), .CNT_WIDTH(16)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in),
        .valid_in(vin2), .ready_in(rdy2), .data_out(do2), .valid_out(vo2),
        .ready_out(ready_out), .busy(busy2), .pkt_count(pc2), .dest_err(derr2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] head_flit(input logic [AW-1:0] dest);
        return {2'b01, 16'h0, 7'd3, dest};
    endfunction

    // Queues the core words and the flits the router must see for one packet.
    task automatic send_packet(input logic [AW-1:0] dest, input logic [PW-1:0] base,
                               input int nwords);
        exp_q.push_back(head_flit(dest));
        for (int i = 0; i < nwords; i++) begin
            word_t w;
            w.data = base + PW'(i);
            w.dest = dest;
            src_q.push_back(w);
            exp_q.push_back({(i == nwords - 1) ? 2'b11 : 2'b10, w.data});
        end
    endtask

    // One cycle: drive at the falling edge, observe #1 later, apply at the rising edge.
    task automatic step();
        logic acc;
        ready_out = (rmode == 0) ? 1'b1 : rpat[cyc % 4];
        v = (src_q.size() != 0);
        if (v) begin
            data_in = src_q[0].data;
            dest_in = src_q[0].dest;
        end
        #1;
        if (m_valid && !ready_out) check("ready_in_backpressure", {31'b0, m_ready_in}, 32'h0);
        if (m_valid && ready_out) begin
            if (exp_q.size() == 0) check("extra_flit", m_data, 32'h0);
            else check("flit", m_data, exp_q.pop_front());
        end
        acc = v && m_ready_in;
        @(posedge clk);
        if (acc) begin
            void'(src_q.pop_front());
            n_acc++;
        end
        cyc++;
        @(negedge clk);
        v = 1'b0;
    endtask

    task automatic run(input int budget, output int n);
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (src_q.size() != 0 || exp_q.size() != 0)
            check("timeout_pending_flits", exp_q.size(), 32'h0);
    endtask

    initial begin
        int n;
        int target;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid_out", {31'b0, m_valid}, 32'h0);
        check("rst_data_out", m_data, 32'h0);
        check("rst_ready_in", {31'b0, m_ready_in}, 32'h0);
        check("rst_busy", {31'b0, m_busy}, 32'h0);
        check("rst_pkt_count", {16'b0, m_pc}, 32'h0);
        check("rst_dest_err", {31'b0, m_derr}, 32'h0);

        // Reference packet, ready_out held high; literal expected flits.
        for (int i = 0; i < 5; i++) begin
            word_t w;
            w.data = 30'h10 + PW'(i);
            w.dest = 7'd7;
            src_q.push_back(w);
        end
        exp_q.push_back(32'h40000187);
        exp_q.push_back(32'h80000010);
        exp_q.push_back(32'h80000011);
        exp_q.push_back(32'h80000012);
        exp_q.push_back(32'h80000013);
        exp_q.push_back(32'hC0000014);
        run(50, n);
        check("p1_cycles", n, 32'd7);
        check("p1_busy", {31'b0, m_busy}, 32'h0);
        check("p1_valid_out", {31'b0, m_valid}, 32'h0);
        check("p1_pkt_count", {16'b0, m_pc}, 32'd1);

        // Same packet under a 1,0,0,1 ready pattern.
        rmode = 1;
        cyc = 0;
        send_packet(7'd7, 30'h10, 5);
        run(100, n);
        rmode = 0;
        check("p2_busy", {31'b0, m_busy}, 32'h0);
        check("p2_pkt_count", {16'b0, m_pc}, 32'd2);

        // Two-flit packets back to back on the second instance.
        sel = 1'b1;
        send_packet(7'd11, 30'h100, 1);
        send_packet(7'd12, 30'h200, 1);
        send_packet(7'd13, 30'h300, 1);
        run(50, n);
        check("b2b_cycles", n, 32'd7);
        check("b2b_pkt_count", {16'b0, m_pc}, 32'd3);
        check("b2b_busy", {31'b0, m_busy}, 32'h0);
        sel = 1'b0;

        // Out-of-range destination: still sent, error is sticky.
        send_packet(7'd100, 30'h55, 5);
        run(50, n);
        check("derr_set", {31'b0, m_derr}, 32'h1);
        check("derr_pkt_count", {16'b0, m_pc}, 32'd3);
        send_packet(7'd2, 30'h66, 5);
        run(50, n);
        check("derr_sticky", {31'b0, m_derr}, 32'h1);

        // Reset mid-packet after the second body word is accepted.
        target = n_acc + 2;
        send_packet(7'd9, 30'h20, 5);
        n = 0;
        while (n_acc < target && n < 50) begin
            step();
            n++;
        end
        check("midrst_accepts", n_acc, target);
        src_q.delete();
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid_out", {31'b0, m_valid}, 32'h0);
        check("midrst_busy", {31'b0, m_busy}, 32'h0);
        check("midrst_pkt_count", {16'b0, m_pc}, 32'h0);
        check("midrst_dest_err", {31'b0, m_derr}, 32'h0);
        send_packet(7'd4, 30'h30, 5);
        run(50, n);
        check("postrst_pkt_count", {16'b0, m_pc}, 32'd1);

        // Counter wrap from all-ones.
        force u_dut6.r_pkt_count = 16'hFFFF;
        #1;
        release u_dut6.r_pkt_count;
        #1;
        check("wrap_preload", {16'b0, m_pc}, 32'h0000FFFF);
        send_packet(7'd5, 30'h40, 5);
        run(50, n);
        check("wrap_pkt_count", {16'b0, m_pc}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
